dff_skid: RTL

Two-entry registered skid buffer that sits on the consumer side of a registered pipeline stage. It adds a valid/ready handshake to the plain capture register used elsewhere in the datapath, so downstream logic can apply backpressure without a combinational ready path. It sustains one word per cycle. Like the plain register, its storage resets to a caller-supplied value.

---
 rtl/dff_skid.sv | 115 +++++++++++
 1 files changed

// File: rtl/dff_skid.sv
// Two-entry registered skid buffer: valid/ready capture register with a skid slot,
// all handshake outputs registered so backpressure never forms a combinational path.
module dff_skid #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [DATA_WIDTH-1:0] reset_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] out_d;
    logic [DATA_WIDTH-1:0] skid_q;
    logic [DATA_WIDTH-1:0] skid_d;
    logic                  s_ready_d;
    logic                  m_valid_d;
    logic [1:0]            occupancy_d;
    logic                  in_xfer_c;
    logic                  out_xfer_c;

    assign in_xfer_c  = s_valid & s_ready;
    assign out_xfer_c = m_valid & m_ready;
    assign m_data     = out_q;

    // Next state, storage updates and next-cycle handshake decode
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        skid_d      = skid_q;
        s_ready_d   = 1'b1;
        m_valid_d   = 1'b0;
        occupancy_d = 2'd0;

        case (state_q)
            ST_EMPTY: begin
                if (in_xfer_c) begin
                    out_d   = s_data;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (in_xfer_c && out_xfer_c) begin
                    out_d = s_data;
                end else if (in_xfer_c) begin
                    skid_d  = s_data;
                    state_d = ST_FULL;
                end else if (out_xfer_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_xfer_c) begin
                    out_d   = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        case (state_d)
            ST_BUSY: begin
                s_ready_d   = 1'b1;
                m_valid_d   = 1'b1;
                occupancy_d = 2'd1;
            end
            ST_FULL: begin
                s_ready_d   = 1'b0;
                m_valid_d   = 1'b1;
                occupancy_d = 2'd2;
            end
            default: begin
                s_ready_d   = 1'b1;
                m_valid_d   = 1'b0;
                occupancy_d = 2'd0;
            end
        endcase
    end

    // State and storage registers; reset discards any handshake in that cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            out_q     <= reset_data;
            skid_q    <= reset_data;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
            s_ready   <= s_ready_d;
            m_valid   <= m_valid_d;
            occupancy <= occupancy_d;
        end
    end

endmodule
